// File: rtl/booth_arbiter.sv
// booth_arbiter: round-robin sharing of one booth_top multiplier among NUM_REQ lanes.
// Optional WAIT-state watchdog is compiled in with `define BOOTH_ARB_TIMEOUT_EN.
module booth_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*W-1:0] a_in,
  input  logic [NUM_REQ*W-1:0] b_in,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   resp_valid,
  output logic [2*W-1:0]       product_out,
  output logic                 busy,
  output logic                 err,
  output logic                 mul_start,
  output logic [W-1:0]         mul_a,
  output logic [W-1:0]         mul_b,
  input  logic [2*W-1:0]       mul_product,
  input  logic                 mul_done
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW:0] NR = (PW+1)'(NUM_REQ);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_ARM   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("booth_arbiter: NUM_REQ must be 2..8 and TIMEOUT >= 1");
  end

  // Handshake: a lane holds req high with stable operands until its one-cycle
  // resp_valid pulse; toward booth_top, mul_start is a one-cycle pulse and the
  // first mul_done seen in WAIT (never in ARM) completes the operation.
  logic [2:0]         state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      lane_q, lane_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] resp_q, resp_d;
  logic [2*W-1:0]     prod_q, prod_d;
  logic               start_q, start_d;
  logic [W-1:0]       mul_a_q, mul_a_d;
  logic [W-1:0]       mul_b_q, mul_b_d;

`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 127) ? $clog2(TIMEOUT + 1) : 7;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  logic               pick_found;
  logic [PW-1:0]      pick_idx;
  logic [PW:0]        rot;
  logic [PW:0]        lane_inc;
  logic [PW-1:0]      ptr_next;
  logic [NUM_REQ-1:0] pick_oh;
  logic [W-1:0]       a_sel, b_sel;

  // First requesting lane at or after the pointer, wrapping past NUM_REQ-1.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    rot        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rot = {1'b0, ptr_q} + (PW+1)'(i);
      if (rot >= NR) rot = rot - NR;
      if (!pick_found && req[rot[PW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = rot[PW-1:0];
      end
    end
  end

  always_comb begin
    pick_oh = '0;
    a_sel   = '0;
    b_sel   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == PW'(i)) begin
        pick_oh[i] = 1'b1;
        a_sel      = a_in[i*W +: W];
        b_sel      = b_in[i*W +: W];
      end
    end
  end

  always_comb begin
    lane_inc = {1'b0, lane_q} + (PW+1)'(1);
    ptr_next = (lane_inc == NR) ? '0 : lane_inc[PW-1:0];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lane_d  = lane_q;
    gnt_d   = gnt_q;
    resp_d  = '0;
    start_d = 1'b0;
    prod_d  = prod_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
`ifdef BOOTH_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          lane_d  = pick_idx;
          gnt_d   = pick_oh;
          mul_a_d = a_sel;
          mul_b_d = b_sel;
          start_d = 1'b1;
          state_d = S_START;
        end
      end
      S_START: state_d = S_ARM;
      S_ARM: begin
        // booth_done may still be high from the previous operation here.
        state_d = S_WAIT;
`ifdef BOOTH_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (mul_done) begin
          prod_d  = mul_product;
          resp_d  = gnt_q;
          state_d = S_RESP;
        end
`ifdef BOOTH_ARB_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          gnt_d   = '0;
          mul_a_d = '0;
          mul_b_d = '0;
          ptr_d   = ptr_next;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      S_RESP: begin
        gnt_d   = '0;
        mul_a_d = '0;
        mul_b_d = '0;
        ptr_d   = ptr_next;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      lane_q  <= '0;
      gnt_q   <= '0;
      resp_q  <= '0;
      prod_q  <= '0;
      start_q <= 1'b0;
      mul_a_q <= '0;
      mul_b_q <= '0;
`ifdef BOOTH_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lane_q  <= lane_d;
      gnt_q   <= gnt_d;
      resp_q  <= resp_d;
      prod_q  <= prod_d;
      start_q <= start_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
`ifdef BOOTH_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign gnt         = gnt_q;
  assign resp_valid  = resp_q;
  assign product_out = prod_q;
  assign busy        = (state_q != S_IDLE);
  assign mul_start   = start_q;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
`ifdef BOOTH_ARB_TIMEOUT_EN
  assign err         = err_q;
`else
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_booth_arbiter.sv
// tb_booth_arbiter: random and directed stimulus against an operation-level model of the
// arbiter, with a behavioural booth_top stub that returns a*b after a random latency.
module tb_booth_arbiter;
  localparam int NR = 4;
  localparam int W  = 8;
  localparam int TO = 64;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NR-1:0]   req = '0;
  logic [NR*W-1:0] a_in = '0;
  logic [NR*W-1:0] b_in = '0;
  logic [NR-1:0]   gnt, resp_valid;
  logic [2*W-1:0]  product_out;
  logic            busy, err, mul_start;
  logic [W-1:0]    mul_a, mul_b;
  logic [2*W-1:0]  mul_product = '0;
  logic            mul_done = 1'b0;

  int checks = 0;
  int errors = 0;
  int n = 0;

  always #5 clk = ~clk;
  always @(posedge clk) n++;

  booth_arbiter #(.NUM_REQ(NR), .W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .resp_valid(resp_valid), .product_out(product_out),
    .busy(busy), .err(err), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_product(mul_product), .mul_done(mul_done)
  );

  // ---------------- operation-level model ----------------
  // One outstanding op: granted at edge m_g, last busy cycle m_e.
  bit             m_active = 1'b0;
  bit             m_to = 1'b0;
  int             m_lane = 0, m_g = 0, m_e = 0, m_err_n = -1, m_ptr = 0;
  logic [W-1:0]   m_a = '0, m_b = '0;
  logic [2*W-1:0] m_prod = '0;
  int             force_lat = 0;

  // scoreboard of observed responses, checked against literal expectations
  int             obs_lane_q[$];
  logic [2*W-1:0] obs_prod_q[$];
  int             obs_err = 0;
  int             exp_lane_q[$];
  logic [2*W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", name, n, act, exp);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle(input logic [NR-1:0] r, input logic [NR*W-1:0] a,
                       input logic [NR*W-1:0] b);
    bit                    act, idle_now;
    logic [NR-1:0]         oh, e_resp;
    int                    lat, l;
    logic signed [2*W-1:0] p;
    @(negedge clk);
    act = m_active && (n <= m_e);
    oh = '0;
    if (act) oh[m_lane] = 1'b1;
    e_resp = (act && !m_to && n == m_e) ? oh : '0;
    if (e_resp != '0) begin
      p = $signed(m_a) * $signed(m_b);
      m_prod = p;
    end
    chk("gnt", gnt, oh);
    chk("busy", busy, act);
    chk("mul_start", mul_start, act && n == m_g);
    chk("resp_valid", resp_valid, e_resp);
    chk("err", err, n == m_err_n);
    chk("product_out", product_out, m_prod);
    if (act) begin
      chk("mul_a", mul_a, m_a);
      chk("mul_b", mul_b, m_b);
    end
    if (resp_valid != '0) begin
      l = -1;
      for (int i = 0; i < NR; i++) if (resp_valid[i]) l = i;
      obs_lane_q.push_back(l);
      obs_prod_q.push_back(product_out);
    end
    if (err) obs_err++;
    idle_now = !act;
    if (act && n == m_e) begin
      m_active = 1'b0;
      m_ptr = (m_lane + 1) % NR;
    end
    // booth_top stub: real done one edge at m_e, optional stale done during ARM
    mul_done = 1'b0;
    mul_product = 16'($urandom);
    if (m_active && !m_to && n + 1 == m_e) begin
      p = $signed(m_a) * $signed(m_b);
      mul_done = 1'b1;
      mul_product = p;
    end else if (m_active && n == m_g + 1) begin
      mul_done = 1'($urandom_range(0, 1));
    end
    req = r;
    a_in = a;
    b_in = b;
    if (idle_now && r != '0) begin
      l = -1;
      for (int i = 0; i < NR; i++) if (l < 0 && r[(m_ptr + i) % NR]) l = (m_ptr + i) % NR;
      m_lane = l;
      m_g = n + 1;
      m_a = a[l*W +: W];
      m_b = b[l*W +: W];
      m_to = 1'b0;
      lat = (force_lat != 0) ? force_lat : int'($urandom_range(3, 8));
`ifdef BOOTH_ARB_TIMEOUT_EN
      if (force_lat == 0) begin
        case ($urandom_range(0, 9))
          0: lat = -1;
          1: lat = TO + 2;
          default: ;
        endcase
      end
`endif
      if (lat < 0) begin
        m_to = 1'b1;
        m_e = m_g + 1 + TO;
        m_err_n = m_e + 1;
      end else begin
        m_e = m_g + lat;
      end
      m_active = 1'b1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_product_out", product_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    m_active = 1'b0;
    m_ptr = 0;
    m_prod = '0;
    m_err_n = -1;
    mul_done = 1'b0;
    req = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_ops(input logic [NR-1:0] r, input logic [NR*W-1:0] a,
                         input logic [NR*W-1:0] b, input int nops);
    int target;
    int k;
    target = obs_lane_q.size() + nops;
    k = 0;
    while (obs_lane_q.size() < target && k < 400) begin
      cycle(r, a, b);
      k++;
    end
    chk("ops_within_bound", obs_lane_q.size() >= target, 1);
    cycle('0, a, b);
  endtask

  task automatic chk_obs(input string name, input int idx);
    if (idx < obs_lane_q.size()) begin
      chk({name, "_lane"}, obs_lane_q[idx], exp_lane_q[idx]);
      chk({name, "_prod"}, obs_prod_q[idx], exp_q[idx]);
    end else begin
      chk({name, "_count"}, obs_lane_q.size(), idx + 1);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    logic [NR-1:0]   rr;
    logic [NR*W-1:0] ra, rb;

    repeat (2) @(negedge clk);
    do_reset();

    // contention from reset: grants 0,1,2,3
    exp_lane_q = {0, 1, 2, 3};
    exp_q = {16'h000C, 16'hFFDD, 16'hFFEE, 16'h000E};
    run_ops(4'b1111, 32'h07FE0503, 32'h0209F904, 4);
    // single op lane 0: 20*16
    exp_lane_q.push_back(0);
    exp_q.push_back(16'h0140);
    run_ops(4'b0001, 32'h00000014, 32'h00000010, 1);
    // signed op lane 2: -3*5
    exp_lane_q.push_back(2);
    exp_q.push_back(16'hFFF1);
    run_ops(4'b0100, 32'h00FD0000, 32'h00050000, 1);
    // fairness: lanes 0,1 held, pointer at 3
    for (int i = 0; i < 2; i++) begin
      exp_lane_q.push_back(0);
      exp_q.push_back(16'hFFB8);
      exp_lane_q.push_back(1);
      exp_q.push_back(16'hFF87);
    end
    run_ops(4'b0011, 32'h00000BF8, 32'h0000F509, 4);
    for (int i = 0; i < 10; i++) chk_obs("directed", i);

    // reset while waiting on the multiplier
    force_lat = 8;
    for (int i = 0; i < 4; i++) cycle(4'b0001, 32'h00000055, 32'h00000033);
    chk("t5_in_wait", busy, 1);
    base = obs_lane_q.size();
    do_reset();
    cycle('0, '0, '0);
    chk("t5_no_resp", obs_lane_q.size(), base);
    force_lat = 0;
    exp_lane_q.push_back(1);
    exp_q.push_back(16'h002A);
    run_ops(4'b0010, 32'h00000600, 32'h00000700, 1);
    chk_obs("t5_after", base);

`ifdef BOOTH_ARB_TIMEOUT_EN
    // watchdog with a silent multiplier
    base = obs_err;
    force_lat = -1;
    cycle(4'b0001, 32'h00000009, 32'h00000009);
    force_lat = 0;
    for (int i = 0; i < TO + 6; i++) cycle('0, '0, '0);
    chk("t6_err_count", obs_err - base, 1);
`endif

    // randomized traffic
    rr = '0;
    ra = '0;
    rb = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(0, 3) == 0) rr[i] = ~rr[i];
        if ($urandom_range(0, 2) == 0) begin
          ra[i*W +: W] = 8'($urandom);
          rb[i*W +: W] = 8'($urandom);
        end
      end
      cycle(rr, ra, rb);
      if (c == 700) do_reset();
    end
    for (int i = 0; i < TO + 12; i++) cycle('0, ra, rb);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout cycle %0d got running expected finished", n);
    $fatal(1, "simulation time limit");
  end

endmodule
